// File: rtl/div_seq.sv
// div_seq: 32-iteration radix-2 restoring HI/LO divider sequencer for the MIPS EX stage.
// Optional feature macro DIV_ZERO_FAST_EN: a divide by zero finishes in one cycle.
module div_seq #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             signed_div,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             annul,
    output logic             stall,
    output logic             ready,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] dvsr_q, dvsr_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic             quo_neg_q, quo_neg_d;
    logic             rem_neg_q, rem_neg_d;
    logic             bzero_q, bzero_d;
    logic             ready_q, ready_d;

    logic [WIDTH:0]   rem_sh_s;
    logic [WIDTH:0]   trial_s;
    logic [WIDTH-1:0] rem_nx_s;
    logic [WIDTH-1:0] quo_nx_s;
    logic [WIDTH-1:0] abs_a_s;
    logic [WIDTH-1:0] abs_b_s;

    // Next-state, datapath iteration and result formatting
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        rem_d     = rem_q;
        quo_d     = quo_q;
        dvsr_d    = dvsr_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        quo_neg_d = quo_neg_q;
        rem_neg_d = rem_neg_q;
        bzero_d   = bzero_q;
        ready_d   = 1'b0;

        rem_sh_s = {rem_q, quo_q[WIDTH-1]};
        trial_s  = rem_sh_s - {1'b0, dvsr_q};
        rem_nx_s = trial_s[WIDTH] ? rem_sh_s[WIDTH-1:0] : trial_s[WIDTH-1:0];
        quo_nx_s = {quo_q[WIDTH-2:0], ~trial_s[WIDTH]};
        abs_a_s  = (signed_div & a[WIDTH-1]) ? -a : a;
        abs_b_s  = (signed_div & b[WIDTH-1]) ? -b : b;

        case (state_q)
            IDLE: begin
                if (start & ~annul) begin
                    dvsr_d    = abs_b_s;
                    quo_d     = abs_a_s;
                    rem_d     = {WIDTH{1'b0}};
                    cnt_d     = {CNT_W{1'b0}};
                    quo_neg_d = signed_div & (a[WIDTH-1] ^ b[WIDTH-1]);
                    rem_neg_d = signed_div & a[WIDTH-1];
                    bzero_d   = (b == {WIDTH{1'b0}});
`ifdef DIV_ZERO_FAST_EN
                    if (b == {WIDTH{1'b0}}) begin
                        state_d = DONE;
                        ready_d = 1'b1;
                        hi_d    = a;
                        lo_d    = {WIDTH{1'b1}};
                    end else begin
                        state_d = RUN;
                    end
`else
                    state_d = RUN;
`endif
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                rem_d = rem_nx_s;
                quo_d = quo_nx_s;
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == {CNT_W{1'b1}}) begin
                    state_d = DONE;
                    ready_d = 1'b1;
                    // With a zero divisor the remainder path reproduces |a|, so the
                    // sign fix-up below returns the raw dividend; only lo is forced.
                    lo_d    = bzero_q ? {WIDTH{1'b1}} : (quo_neg_q ? -quo_nx_s : quo_nx_s);
                    hi_d    = rem_neg_q ? -rem_nx_s : rem_nx_s;
                end else begin
                    state_d = RUN;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (annul) begin
            state_d = IDLE;
            ready_d = 1'b0;
            hi_d    = hi_q;
            lo_d    = lo_q;
        end else begin
            state_d = state_d;
        end
    end

    // State, datapath and result registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= {CNT_W{1'b0}};
            rem_q     <= {WIDTH{1'b0}};
            quo_q     <= {WIDTH{1'b0}};
            dvsr_q    <= {WIDTH{1'b0}};
            hi_q      <= {WIDTH{1'b0}};
            lo_q      <= {WIDTH{1'b0}};
            quo_neg_q <= 1'b0;
            rem_neg_q <= 1'b0;
            bzero_q   <= 1'b0;
            ready_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            rem_q     <= rem_d;
            quo_q     <= quo_d;
            dvsr_q    <= dvsr_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            quo_neg_q <= quo_neg_d;
            rem_neg_q <= rem_neg_d;
            bzero_q   <= bzero_d;
            ready_q   <= ready_d;
        end
    end

    // A flush in the DONE cycle must keep HI/LO from being written
    assign ready = ready_q & ~annul;
    assign stall = (((state_q == IDLE) & start & ~annul) | (state_q == RUN)) & ~rst;
    assign hi    = hi_q;
    assign lo    = lo_q;

endmodule
